// File: rtl/scoreboard.sv
// Register scoreboard: per-register pending bit and writeback row shift register.
// Feeds the hazard detector with issue/decode/WAW reads and the writeback-port column.
module scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ROW_W    = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4:0]          iss_addr_a,
  input  logic [4:0]          iss_addr_b,
  output logic                iss_pending_a,
  output logic                iss_pending_b,
  output logic [ROW_W-1:0]    iss_row_a,
  output logic [ROW_W-1:0]    iss_row_b,
  input  logic [4:0]          id_addr_a,
  input  logic [4:0]          id_addr_b,
  output logic                id_pending_a,
  output logic                id_pending_b,
  output logic [ROW_W-1:0]    id_row_a,
  output logic [ROW_W-1:0]    id_row_b,
  input  logic [4:0]          id_waw_addr,
  output logic                id_waw_pending,
  output logic [ROW_W-1:0]    id_waw_row,
  input  logic                iss_writereg,
  input  logic [4:0]          iss_writeaddr,
  input  logic [2:0]          iss_latency,
  input  logic                iss_stalled,
  output logic [NUM_REGS-1:0] sb_haz_column,
  input  logic                vl_done,
  input  logic [4:0]          vl_addr,
  output logic                sb_any_pending
);

  localparam logic [2:0] LMAX = 3'(ROW_W);

  logic [NUM_REGS-1:0]            pend;
  logic [NUM_REGS-1:0]            pend_n;
  logic [NUM_REGS-1:0][ROW_W-1:0] row;
  logic [NUM_REGS-1:0][ROW_W-1:0] row_n;

  logic [2:0]       lat_c;
  logic             issue_fire;
  logic [ROW_W-1:0] issue_row;

  assign lat_c      = (iss_latency > LMAX) ? LMAX : iss_latency;
  assign issue_fire = iss_writereg & ~iss_stalled & (iss_writeaddr != 5'd0);
  assign issue_row  = (lat_c == 3'd0) ? '0 : ROW_W'(1) << (lat_c - 3'd1);

  // Entry 0 is never touched, so it reads back as zero forever.
  always_comb begin
    pend_n = pend;
    row_n  = row;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue_fire && iss_writeaddr == 5'(r)) begin
        pend_n[r] = 1'b1;
        row_n[r]  = issue_row;
      end else if (vl_done && vl_addr == 5'(r) && row[r] == '0) begin
        pend_n[r] = 1'b0;
      end else if (row[r] == ROW_W'(1)) begin
        pend_n[r] = 1'b0;
        row_n[r]  = '0;
      end else begin
        row_n[r] = row[r] >> 1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= '0;
      row  <= '0;
    end else begin
      pend <= pend_n;
      row  <= row_n;
    end
  end

  assign iss_pending_a  = pend[iss_addr_a];
  assign iss_pending_b  = pend[iss_addr_b];
  assign iss_row_a      = row[iss_addr_a];
  assign iss_row_b      = row[iss_addr_b];
  assign id_pending_a   = pend[id_addr_a];
  assign id_pending_b   = pend[id_addr_b];
  assign id_row_a       = row[id_addr_a];
  assign id_row_b       = row[id_addr_b];
  assign id_waw_pending = pend[id_waw_addr];
  assign id_waw_row     = row[id_waw_addr];
  assign sb_any_pending = |pend;

  // Bit r flags that register r already owns the writeback slot iss_latency away.
  always_comb begin
    sb_haz_column = '0;
    if (lat_c != 3'd0) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        sb_haz_column[r] = row[r][lat_c - 3'd1];
      end
    end
  end

  lat_range: assert property (@(posedge clock) disable iff (reset)
    !(iss_writereg && !iss_stalled && iss_latency > LMAX));

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard: stimulus queues expected reads,
// a negedge monitor pops and compares them against the DUT.
module tb_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  iss_addr_a = '0, iss_addr_b = '0;
  logic        iss_pending_a, iss_pending_b;
  logic [4:0]  iss_row_a, iss_row_b;
  logic [4:0]  id_addr_a = '0, id_addr_b = '0;
  logic        id_pending_a, id_pending_b;
  logic [4:0]  id_row_a, id_row_b;
  logic [4:0]  id_waw_addr = '0;
  logic        id_waw_pending;
  logic [4:0]  id_waw_row;
  logic        iss_writereg = 1'b0;
  logic [4:0]  iss_writeaddr = '0;
  logic [2:0]  iss_latency = '0;
  logic        iss_stalled = 1'b0;
  logic [31:0] sb_haz_column;
  logic        vl_done = 1'b0;
  logic [4:0]  vl_addr = '0;
  logic        sb_any_pending;

  scoreboard dut (
    .clock(clock), .reset(reset),
    .iss_addr_a(iss_addr_a), .iss_addr_b(iss_addr_b),
    .iss_pending_a(iss_pending_a), .iss_pending_b(iss_pending_b),
    .iss_row_a(iss_row_a), .iss_row_b(iss_row_b),
    .id_addr_a(id_addr_a), .id_addr_b(id_addr_b),
    .id_pending_a(id_pending_a), .id_pending_b(id_pending_b),
    .id_row_a(id_row_a), .id_row_b(id_row_b),
    .id_waw_addr(id_waw_addr), .id_waw_pending(id_waw_pending),
    .id_waw_row(id_waw_row),
    .iss_writereg(iss_writereg), .iss_writeaddr(iss_writeaddr),
    .iss_latency(iss_latency), .iss_stalled(iss_stalled),
    .sb_haz_column(sb_haz_column),
    .vl_done(vl_done), .vl_addr(vl_addr),
    .sb_any_pending(sb_any_pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  localparam int P_ISS_A = 0, P_ID_A = 1, P_WAW = 2, P_ISS_B = 3;
  localparam int P_ID_B = 4, P_ANY = 5, P_COL = 6;

  task automatic push(input string n, input int p, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.port = p;
    e.val  = v;
    q.push_back(e);
  endtask

  // Port a side (iss_a, id_a, waw) probes ra; port b side probes rb.
  task automatic expect_reg(input string n,
                            input logic [4:0] ra, input logic pa, input logic [4:0] wa,
                            input logic [4:0] rb, input logic pb, input logic [4:0] wb);
    iss_addr_a  = ra;
    id_addr_a   = ra;
    id_waw_addr = ra;
    iss_addr_b  = rb;
    id_addr_b   = rb;
    push(n, P_ISS_A, {26'd0, pa, wa});
    push(n, P_ID_A,  {26'd0, pa, wa});
    push(n, P_WAW,   {26'd0, pa, wa});
    push(n, P_ISS_B, {26'd0, pb, wb});
    push(n, P_ID_B,  {26'd0, pb, wb});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    iss_writereg  = 1'b0;
    iss_stalled   = 1'b0;
    iss_latency   = 3'd0;
    iss_writeaddr = 5'd0;
    vl_done       = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r, input logic [2:0] lat);
    iss_writereg  = 1'b1;
    iss_writeaddr = r;
    iss_latency   = lat;
  endtask

  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.port)
        P_ISS_A: act = {26'd0, iss_pending_a, iss_row_a};
        P_ID_A:  act = {26'd0, id_pending_a, id_row_a};
        P_WAW:   act = {26'd0, id_waw_pending, id_waw_row};
        P_ISS_B: act = {26'd0, iss_pending_b, iss_row_b};
        P_ID_B:  act = {26'd0, id_pending_b, id_row_b};
        P_ANY:   act = {31'd0, sb_any_pending};
        P_COL:   act = sb_haz_column;
        default: act = 'x;
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s port=%0d got=%h exp=%h", e.name, e.port, act, e.val);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct { logic [2:0] lat; logic [31:0] col; } col_t;
  col_t col_vec[3];

  initial begin
    col_vec[0] = '{3'd2, 32'h10};
    col_vec[1] = '{3'd3, 32'h0};
    col_vec[2] = '{3'd0, 32'h0};

    #2;
    expect_reg("reset_state", 5'd5, 1'b0, 5'd0, 5'd7, 1'b0, 5'd0);
    push("reset_any", P_ANY, 32'd0);
    #10 reset = 1'b0;

    // fixed latency 3 on r5
    step();
    issue(5'd5, 3'd3);
    expect_reg("fix_no_bypass", 5'd5, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    step(); idle();
    expect_reg("fix_c1", 5'd5, 1'b1, 5'b00100, 5'd0, 1'b0, 5'd0);
    push("fix_any", P_ANY, 32'd1);
    step();
    expect_reg("fix_c2", 5'd5, 1'b1, 5'b00010, 5'd0, 1'b0, 5'd0);
    step();
    expect_reg("fix_c3", 5'd5, 1'b1, 5'b00001, 5'd0, 1'b0, 5'd0);
    step();
    expect_reg("fix_c4", 5'd5, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    push("fix_any_clr", P_ANY, 32'd0);

    // variable latency on r7
    step();
    issue(5'd7, 3'd0);
    step(); idle();
    for (int i = 0; i < 10; i++) begin
      expect_reg("var_hold", 5'd7, 1'b1, 5'd0, 5'd5, 1'b0, 5'd0);
      if (i == 9) begin
        vl_done = 1'b1;
        vl_addr = 5'd7;
      end
      step(); idle();
    end
    expect_reg("var_done", 5'd7, 1'b0, 5'd0, 5'd5, 1'b0, 5'd0);
    push("var_any", P_ANY, 32'd0);

    // structural column against r4 issued at latency 4
    foreach (col_vec[k]) begin
      step();
      issue(5'd4, 3'd4);
      step(); idle();
      step();
      step();
      expect_reg("col_row", 5'd4, 1'b1, 5'b00010, 5'd0, 1'b0, 5'd0);
      iss_latency = col_vec[k].lat;
      push("col", P_COL, col_vec[k].col);
      step(); idle();
      step();
    end

    // stall and r0 gating
    step();
    issue(5'd9, 3'd2);
    iss_stalled = 1'b1;
    step(); idle();
    expect_reg("stall", 5'd9, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    push("stall_any", P_ANY, 32'd0);
    issue(5'd0, 3'd3);
    step(); idle();
    expect_reg("r0_write", 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    push("r0_any", P_ANY, 32'd0);

    // issue to r3 in its retire cycle
    step();
    issue(5'd3, 3'd1);
    step(); idle();
    expect_reg("coll_ret", 5'd3, 1'b1, 5'b00001, 5'd0, 1'b0, 5'd0);
    issue(5'd3, 3'd2);
    step(); idle();
    expect_reg("coll_new", 5'd3, 1'b1, 5'b00010, 5'd0, 1'b0, 5'd0);
    step();
    expect_reg("coll_c2", 5'd3, 1'b1, 5'b00001, 5'd0, 1'b0, 5'd0);
    step();
    expect_reg("coll_done", 5'd3, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);

    // vl_done for r6 after a fixed-latency overwrite
    step();
    issue(5'd6, 3'd0);
    step(); idle();
    expect_reg("ow_var", 5'd0, 1'b0, 5'd0, 5'd6, 1'b1, 5'd0);
    issue(5'd6, 3'd3);
    step(); idle();
    expect_reg("ow_fix", 5'd0, 1'b0, 5'd0, 5'd6, 1'b1, 5'b00100);
    vl_done = 1'b1;
    vl_addr = 5'd6;
    step(); idle();
    expect_reg("ow_vl_ignored", 5'd0, 1'b0, 5'd0, 5'd6, 1'b1, 5'b00010);
    step();
    step();
    expect_reg("ow_done", 5'd0, 1'b0, 5'd0, 5'd6, 1'b0, 5'd0);
    push("ow_any", P_ANY, 32'd0);

    // asynchronous reset with three outstanding writes
    step();
    issue(5'd2, 3'd0);
    step();
    issue(5'd10, 3'd0);
    step();
    issue(5'd11, 3'd5);
    step(); idle();
    expect_reg("pre_rst", 5'd11, 1'b1, 5'b10000, 5'd2, 1'b1, 5'd0);
    push("pre_rst_any", P_ANY, 32'd1);
    step();
    #1 reset = 1'b1;
    vl_done = 1'b1;
    vl_addr = 5'd2;
    expect_reg("async_rst", 5'd11, 1'b0, 5'd0, 5'd10, 1'b0, 5'd0);
    push("async_rst_any", P_ANY, 32'd0);
    #5 reset = 1'b0;
    idle();
    step();
    expect_reg("post_rst", 5'd2, 1'b0, 5'd0, 5'd10, 1'b0, 5'd0);
    push("post_rst_any", P_ANY, 32'd0);

    step();
    step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d entries exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
